// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control sequencer: control states,
// opcode and addressing-mode enums, and the instruction-length helper.
package control_pkg;

  typedef enum logic [5:0] {
    S_INIT    = 6'd0,
    S_FETCH0  = 6'd1,
    S_FETCH1  = 6'd2,
    S_FETCH2  = 6'd3,
    S_FETCH3  = 6'd4,
    S_DECODE  = 6'd5,
    S_ALUPREP = 6'd6,
    S_LDIMM   = 6'd7,
    S_ALUIMM  = 6'd8,
    S_REG     = 6'd9,
    S_MDADDR  = 6'd10,
    S_MDRD    = 6'd11,
    S_PC0     = 6'd12,
    S_PC1     = 6'd13,
    S_PC2     = 6'd14,
    S_PC3     = 6'd15,
    S_PC4     = 6'd16,
    S_ASR     = 6'd17,
    S_LSR     = 6'd18,
    S_ASL     = 6'd19,
    S_LSL     = 6'd20,
    S_JMP     = 6'd21,
    S_JZ      = 6'd22,
    S_JNZ     = 6'd23,
    S_POP0    = 6'd24,
    S_PUSH0   = 6'd25,
    S_POP1    = 6'd26,
    S_PUSH1   = 6'd27,
    S_ST      = 6'd28,
    S_SHWB    = 6'd29,
    S_ALUWB   = 6'd30,
    S_HALT    = 6'd31,
    S_PCINC   = 6'd32
  } state_e;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_LD   = 5'd1,
    OP_ADD  = 5'd2,
    OP_SUB  = 5'd3,
    OP_AND  = 5'd4,
    OP_OR   = 5'd5,
    OP_ASR  = 5'd6,
    OP_LSR  = 5'd7,
    OP_ASL  = 5'd8,
    OP_LSL  = 5'd9,
    OP_JMP  = 5'd10,
    OP_JZ   = 5'd11,
    OP_JNZ  = 5'd12,
    OP_PUSH = 5'd13,
    OP_POP  = 5'd14,
    OP_ST   = 5'd15,
    OP_HALT = 5'd31
  } opcode_e;

  typedef enum logic [1:0] {
    AM_IMM    = 2'b00,
    AM_REG    = 2'b01,
    AM_MEMDIR = 2'b10,
    AM_PCREL  = 2'b11
  } amode_e;

  function automatic logic [2:0] instr_len(input logic [4:0] opcode, input logic [1:0] amode);
    logic [2:0] len;
    len = 3'd1;
    case (opcode)
      OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        case (amode)
          AM_IMM:  len = 3'd4;
          AM_REG:  len = 3'd2;
          default: len = 3'd3;
        endcase
      end
      OP_ST:                len = 3'd2;
      OP_JMP, OP_JZ, OP_JNZ: len = 3'd3;
      default:              len = 3'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Next-state engine of the multicycle control unit: fetches instruction
// bytes with memory wait handling and walks each opcode through its states.
module control_sequencer
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  input  logic       zero,
  output logic [5:0] state,
  output logic       halted,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  logic       halted_q, halted_d;
  logic [2:0] len_fetch;
  opcode_e    dec_op;
  amode_e     dec_am;

  // op_q[0] carries no meaning; kept only because the whole byte is latched
  logic       unused_op_bit;
  assign unused_op_bit = op_q[0];

  assign len_fetch = instr_len(mem_rdata[7:3], mem_rdata[2:1]);
  assign dec_op    = opcode_e'(op_q[7:3]);
  assign dec_am    = amode_e'(op_q[2:1]);

  function automatic state_e operand_entry(input logic is_ld, input amode_e am);
    state_e s;
    case (am)
      AM_IMM:    s = is_ld ? S_LDIMM : S_ALUIMM;
      AM_REG:    s = S_REG;
      AM_MEMDIR: s = S_MDADDR;
      default:   s = S_PC0;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH0;
      S_FETCH0: begin
        if (mem_ready) begin
          op_d    = mem_rdata;
          state_d = (len_fetch >= 3'd2) ? S_FETCH1 : S_DECODE;
        end
      end
      S_FETCH1: if (mem_ready) state_d = (instr_len(op_q[7:3], op_q[2:1]) >= 3'd3) ? S_FETCH2 : S_DECODE;
      S_FETCH2: if (mem_ready) state_d = (instr_len(op_q[7:3], op_q[2:1]) == 3'd4) ? S_FETCH3 : S_DECODE;
      S_FETCH3: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (dec_op)
          OP_NOP:                      state_d = S_PCINC;
          OP_LD:                       state_d = operand_entry(1'b1, dec_am);
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_ALUPREP;
          OP_ASR:                      state_d = S_ASR;
          OP_LSR:                      state_d = S_LSR;
          OP_ASL:                      state_d = S_ASL;
          OP_LSL:                      state_d = S_LSL;
          OP_JMP:                      state_d = S_JMP;
          OP_JZ:                       state_d = S_JZ;
          OP_JNZ:                      state_d = S_JNZ;
          OP_PUSH:                     state_d = S_PUSH0;
          OP_POP:                      state_d = S_POP0;
          OP_ST:                       state_d = S_ST;
          OP_HALT:                     state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_ALUPREP: state_d = operand_entry(1'b0, dec_am);
      S_LDIMM:   state_d = S_PCINC;
      S_ALUIMM:  state_d = S_ALUWB;
      S_REG:     state_d = S_ALUWB;
      S_MDADDR:  if (mem_ready) state_d = S_MDRD;
      S_MDRD:    state_d = S_ALUWB;
      S_PC0:     state_d = S_PC1;
      S_PC1:     state_d = S_PC2;
      S_PC2:     state_d = S_PC3;
      S_PC3:     if (mem_ready) state_d = S_PC4;
      S_PC4:     state_d = S_ALUWB;
      S_ASR, S_LSR, S_ASL, S_LSL: state_d = S_SHWB;
      S_JMP:     state_d = S_FETCH0;
      S_JZ:      state_d = zero ? S_FETCH0 : S_PCINC;
      S_JNZ:     state_d = zero ? S_PCINC : S_FETCH0;
      S_POP0:    if (mem_ready) state_d = S_POP1;
      S_POP1:    state_d = S_PCINC;
      S_PUSH0:   state_d = S_PUSH1;
      S_PUSH1:   state_d = S_PCINC;
      S_ST:      state_d = S_PCINC;
      S_SHWB:    state_d = S_PCINC;
      S_ALUWB:   state_d = S_PCINC;
      S_HALT:    state_d = S_HALT;
      S_PCINC:   state_d = S_FETCH0;
      default: begin
        state_d   = S_HALT;
        illegal_d = 1'b1;
      end
    endcase
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_INIT;
      op_q      <= '0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
    end
  end

  assign state   = state_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks hand-derived state sequences
// for each instruction class, wait states, jumps, halt, illegal and reset.
module tb_control_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       zero;
  logic [5:0] state;
  logic       halted;
  logic       illegal;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  control_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .zero      (zero),
    .state     (state),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_state(input string tag, input int exp);
    tick();
    chk(tag, {2'b00, state}, exp[7:0]);
  endtask

  task automatic run_q(input string tag);
    while (exp_q.size() > 0) begin
      tick_state(tag, exp_q.pop_front());
    end
  endtask

  initial begin
    reset     = 1'b0;
    mem_rdata = 8'h00;
    mem_ready = 1'b1;
    zero      = 1'b0;
    tick();
    chk("rst_state", {2'b00, state}, 8'd0);
    chk("rst_halted", {7'd0, halted}, 8'd0);
    chk("rst_illegal", {7'd0, illegal}, 8'd0);
    tick();
    reset = 1'b1;

    // NOP
    exp_q = '{1, 5, 32, 1};
    run_q("nop");
    chk("nop_halted", {7'd0, halted}, 8'd0);
    chk("nop_illegal", {7'd0, illegal}, 8'd0);

    // LD imm with two wait cycles in state 2
    mem_rdata = 8'h08;
    tick_state("ldimm", 2);
    mem_ready = 1'b0;
    tick_state("ldimm_w", 2);
    tick_state("ldimm_w", 2);
    mem_ready = 1'b1;
    exp_q = '{3, 4, 5, 7, 32, 1};
    run_q("ldimm");

    // ADD memdir then SUB pcrel
    mem_rdata = 8'h14;
    exp_q = '{2, 3, 5, 6, 10, 11, 30, 32, 1};
    run_q("addmd");
    mem_rdata = 8'h1E;
    exp_q = '{2, 3, 5, 6, 12, 13, 14, 15, 16, 30, 32, 1};
    run_q("subpc");

    // ADD reg with a wait in state 1
    mem_rdata = 8'h12;
    mem_ready = 1'b0;
    tick_state("addreg_w", 1);
    mem_ready = 1'b1;
    exp_q = '{2, 5, 6, 9, 30, 32, 1};
    run_q("addreg");

    // JZ taken / not taken, JNZ inverse
    mem_rdata = 8'h58;
    zero = 1'b1;
    exp_q = '{2, 3, 5, 22, 1};
    run_q("jz_t");
    zero = 1'b0;
    exp_q = '{2, 3, 5, 22, 32, 1};
    run_q("jz_nt");
    mem_rdata = 8'h60;
    exp_q = '{2, 3, 5, 23, 1};
    run_q("jnz_t");
    zero = 1'b1;
    exp_q = '{2, 3, 5, 23, 32, 1};
    run_q("jnz_nt");
    zero = 1'b0;

    // JMP, ASR, PUSH, POP with wait, ST
    mem_rdata = 8'h50;
    exp_q = '{2, 3, 5, 21, 1};
    run_q("jmp");
    mem_rdata = 8'h30;
    exp_q = '{5, 17, 29, 32, 1};
    run_q("asr");
    mem_rdata = 8'h68;
    exp_q = '{5, 25, 27, 32, 1};
    run_q("push");
    mem_rdata = 8'h70;
    tick_state("pop", 5);
    tick_state("pop", 24);
    mem_ready = 1'b0;
    tick_state("pop_w", 24);
    mem_ready = 1'b1;
    exp_q = '{26, 32, 1};
    run_q("pop");
    mem_rdata = 8'h78;
    exp_q = '{2, 5, 28, 32, 1};
    run_q("st");

    // Reset mid-instruction in state 15
    mem_rdata = 8'h1E;
    exp_q = '{2, 3, 5, 6, 12, 13, 14, 15};
    run_q("rst_mid");
    reset = 1'b0;
    tick_state("rst_mid_0", 0);
    reset = 1'b1;
    tick_state("rst_mid_1", 1);

    // HALT
    mem_rdata = 8'hF8;
    tick_state("halt", 5);
    chk("halt_h5", {7'd0, halted}, 8'd0);
    tick_state("halt", 31);
    chk("halt_h", {7'd0, halted}, 8'd1);
    chk("halt_ill", {7'd0, illegal}, 8'd0);
    tick_state("halt_hold", 31);
    reset = 1'b0;
    tick_state("halt_rst", 0);
    chk("halt_rst_h", {7'd0, halted}, 8'd0);
    reset = 1'b1;
    tick_state("ill_start", 1);

    // Illegal opcode 16
    mem_rdata = 8'h80;
    tick_state("ill", 5);
    chk("ill_pre", {7'd0, illegal}, 8'd0);
    tick_state("ill", 31);
    chk("ill_flag", {7'd0, illegal}, 8'd1);
    chk("ill_halted", {7'd0, halted}, 8'd1);
    for (int i = 0; i < 20; i++) begin
      tick_state("ill_hold", 31);
    end
    chk("ill_sticky", {7'd0, illegal}, 8'd1);
    reset = 1'b0;
    tick_state("ill_rst", 0);
    chk("ill_rst_flag", {7'd0, illegal}, 8'd0);
    chk("ill_rst_h", {7'd0, halted}, 8'd0);
    reset = 1'b1;
    tick_state("ill_rel", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
